// File: rtl/line_backing_mem_pkg.sv
// Shared definitions for the line backing memory: FSM state encoding,
// default line geometry and the CLOG2 helper macro.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package line_backing_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lbm_state_e;

    localparam int LINE_SIZE = 16;
    localparam int LINE_W    = LINE_SIZE * 8;
    localparam int OFFSET_W  = `CLOG2(LINE_SIZE);

endpackage

// File: rtl/line_backing_mem_latency_counter.sv
// Load/decrement down-counter used to time the fixed access latency.
// The count saturates at zero; zero is decoded from the registered count.
module latency_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority over decrement, never wraps below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/line_backing_mem.sv
// Line-granular backing memory behind the data cache. Accepts one whole-line
// request at a time, waits a fixed latency, then returns (read), commits
// (write) or swaps (read+write) the addressed line.
module line_backing_mem #(
    parameter int LINE_SIZE = line_backing_mem_pkg::LINE_SIZE,
    parameter int NUM_LINES = 256,
    parameter int DELAY     = 50
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_input_valid,
    input  logic [31:0]            addr,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [LINE_SIZE*8-1:0] din,
    output logic                   mem_ready,
    output logic                   is_output_valid,
    output logic [LINE_SIZE*8-1:0] dout
);

    import line_backing_mem_pkg::*;

    localparam int DATA_W = LINE_SIZE * 8;
    localparam int OFF_W  = `CLOG2(LINE_SIZE);
    localparam int IDX_W  = `CLOG2(NUM_LINES);
    localparam int CNT_W  = `CLOG2(DELAY) + 1;

    lbm_state_e        state_r;
    lbm_state_e        state_s;
    logic              accept_s;
    logic              done_s;
    logic              dec_s;
    logic              zero_s;
    logic [IDX_W-1:0]  idx_r;
    logic              rd_r;
    logic              wr_r;
    logic [DATA_W-1:0] din_r;
    logic [DATA_W-1:0] dout_r;
    logic              unused_addr_s;

    // Storage is deliberately outside the reset domain: contents survive reset.
    logic [DATA_W-1:0] mem_r [NUM_LINES];

    // Only the index field of the address matters; upper bits alias.
    assign unused_addr_s = ^addr;

    latency_counter #(
        .W (CNT_W)
    ) u_latency_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_s),
        .load_val (CNT_W'(DELAY - 1)),
        .dec      (dec_s),
        .zero     (zero_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus accept / completion strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        done_s   = 1'b0;
        dec_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_input_valid && (mem_read || mem_write)) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                dec_s = 1'b1;
                if (zero_s) begin
                    done_s  = 1'b1;
                    state_s = rd_r ? RESP : IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Capture the request so inputs can change freely while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r <= '0;
            rd_r  <= 1'b0;
            wr_r  <= 1'b0;
            din_r <= '0;
        end else if (accept_s) begin
            idx_r <= addr[OFF_W +: IDX_W];
            rd_r  <= mem_read;
            wr_r  <= mem_write;
            din_r <= din;
        end
    end

    // Read data register: loaded with the pre-write contents on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r <= '0;
        end else if (done_s && rd_r) begin
            dout_r <= mem_r[idx_r];
        end
    end

    // Array write on completion; an edge under reset never commits.
    always_ff @(posedge clk) begin
        if (!reset && done_s && wr_r) begin
            mem_r[idx_r] <= din_r;
        end
    end

    assign mem_ready       = (state_r == IDLE);
    assign is_output_valid = (state_r == RESP);
    assign dout            = dout_r;

endmodule

// File: tb/tb_line_backing_mem.sv
// Self-checking bench for line_backing_mem: a DELAY=4 / 16-line instance
// driven from a vector table plus hand sequences, and a DELAY=1 instance.
module tb_line_backing_mem;

    localparam int DLY = 4;

    logic         clk;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] din;
    logic         mem_ready;
    logic         is_output_valid;
    logic [127:0] dout;

    logic         d1_valid;
    logic [31:0]  d1_addr;
    logic         d1_rd;
    logic         d1_wr;
    logic [127:0] d1_din;
    logic         d1_ready;
    logic         d1_ovalid;
    logic [127:0] d1_dout;

    int n_checks;
    int n_errors;
    logic [127:0] exp_q[$];

    localparam logic [127:0] LX = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] LA = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
    localparam logic [127:0] LB = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
    localparam logic [127:0] LC = 128'hCCCC0001_CCCC0002_CCCC0003_CCCC0004;
    localparam logic [127:0] LD = 128'hDDDD0001_DDDD0002_DDDD0003_DDDD0004;
    localparam logic [127:0] LE = 128'hEEEE0001_EEEE0002_EEEE0003_EEEE0004;
    localparam logic [127:0] LF = 128'hFFFF0001_FFFF0002_FFFF0003_FFFF0004;
    localparam logic [127:0] LG = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

    typedef struct {
        logic [31:0]  addr;
        logic         rd;
        logic         wr;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[9];

    line_backing_mem #(
        .LINE_SIZE (16),
        .NUM_LINES (16),
        .DELAY     (DLY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .mem_ready       (mem_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout)
    );

    line_backing_mem #(
        .LINE_SIZE (16),
        .NUM_LINES (16),
        .DELAY     (1)
    ) dut_d1 (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (d1_valid),
        .addr            (d1_addr),
        .mem_read        (d1_rd),
        .mem_write       (d1_wr),
        .din             (d1_din),
        .mem_ready       (d1_ready),
        .is_output_valid (d1_ovalid),
        .dout            (d1_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every read response is compared against the queued expectation.
    always @(negedge clk) begin
        if (is_output_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got dout %h expected no response", dout);
            end else begin
                chk("read_data", dout, exp_q.pop_front());
            end
        end
    end

    // Issue one request at a negedge and check ready/valid timing relative to acceptance.
    task automatic req(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [127:0] d, input logic [127:0] e);
        int vpos;
        int rpos;
        for (int i = 0; i < 200 && mem_ready !== 1'b1; i++) @(negedge clk);
        chk("ready_wait", {127'd0, mem_ready}, 128'd1);
        is_input_valid = 1'b1;
        addr = a;
        mem_read = rd;
        mem_write = wr;
        din = d;
        if (rd) exp_q.push_back(e);
        @(negedge clk);
        is_input_valid = 1'b0;
        vpos = -1;
        rpos = -1;
        for (int n = 0; n < 100; n++) begin
            if (is_output_valid === 1'b1 && vpos < 0) vpos = n;
            if (mem_ready === 1'b1) begin
                rpos = n;
                break;
            end
            @(negedge clk);
        end
        chk("ready_latency", 128'(rpos), rd ? 128'(DLY + 1) : 128'(DLY));
        chk("valid_latency", 128'(vpos), rd ? 128'(DLY) : 128'(-1));
    endtask

    initial begin
        int v1;
        int v2;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        is_input_valid = 1'b0;
        addr = 32'd0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        din = 128'd0;
        d1_valid = 1'b0;
        d1_addr = 32'd0;
        d1_rd = 1'b0;
        d1_wr = 1'b0;
        d1_din = 128'd0;

        vecs[0] = '{32'h0000_0040, 1'b0, 1'b1, LX,     128'd0};
        vecs[1] = '{32'h0000_004C, 1'b1, 1'b0, 128'd0, LX};
        vecs[2] = '{32'h0000_0010, 1'b0, 1'b1, LA,     128'd0};
        vecs[3] = '{32'h0000_0110, 1'b0, 1'b1, LB,     128'd0};
        vecs[4] = '{32'h0000_0010, 1'b1, 1'b0, 128'd0, LB};
        vecs[5] = '{32'h0000_0080, 1'b0, 1'b1, LC,     128'd0};
        vecs[6] = '{32'h0000_0080, 1'b1, 1'b1, LD,     LC};
        vecs[7] = '{32'h0000_0080, 1'b1, 1'b0, 128'd0, LD};
        vecs[8] = '{32'h0000_0020, 1'b0, 1'b1, LF,     128'd0};

        // Reset asserted mid-clock: outputs must follow without an edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", {127'd0, mem_ready}, 128'd1);
        chk("rst_valid", {127'd0, is_output_valid}, 128'd0);
        chk("rst_dout", dout, 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            req(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].din, vecs[i].exp);
        end
        chk("dout_hold", dout, LD);

        // Valid without an operation is ignored.
        is_input_valid = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("noop_ignored", {127'd0, mem_ready}, 128'd1);
        is_input_valid = 1'b0;
        @(negedge clk);

        // Reset during BUSY aborts a pending write to line 0x20.
        is_input_valid = 1'b1;
        addr = 32'h20;
        mem_read = 1'b0;
        mem_write = 1'b1;
        din = LE;
        @(negedge clk);
        is_input_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midbusy_rst_ready", {127'd0, mem_ready}, 128'd1);
        chk("midbusy_rst_valid", {127'd0, is_output_valid}, 128'd0);
        chk("midbusy_rst_dout", dout, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        req(32'h20, 1'b1, 1'b0, 128'd0, LF);

        // Back-to-back with valid held high and addr changing during BUSY.
        is_input_valid = 1'b1;
        addr = 32'h40;
        mem_read = 1'b1;
        mem_write = 1'b0;
        exp_q.push_back(LX);
        exp_q.push_back(LD);
        v1 = -1;
        v2 = -1;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            if (is_output_valid === 1'b1) begin
                if (v1 < 0) v1 = n;
                else if (v2 < 0) v2 = n;
            end
            if (n == 1) addr = 32'h84;
            if (n == DLY + 1) chk("b2b_idle_gap", {127'd0, mem_ready}, 128'd1);
            if (n == DLY + 2) begin
                chk("b2b_second_accept", {127'd0, mem_ready}, 128'd0);
                is_input_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_first_valid", 128'(v1), 128'(DLY));
        chk("b2b_second_valid", 128'(v2), 128'(2 * DLY + 2));

        // DELAY=1 instance: write then read.
        d1_valid = 1'b1;
        d1_addr = 32'h30;
        d1_wr = 1'b1;
        d1_rd = 1'b0;
        d1_din = LG;
        @(negedge clk);
        d1_valid = 1'b0;
        chk("d1_wr_busy", {127'd0, d1_ready}, 128'd0);
        @(negedge clk);
        chk("d1_wr_done", {127'd0, d1_ready}, 128'd1);
        d1_valid = 1'b1;
        d1_addr = 32'h3F;
        d1_wr = 1'b0;
        d1_rd = 1'b1;
        @(negedge clk);
        d1_valid = 1'b0;
        chk("d1_rd_busy", {126'd0, d1_ready, d1_ovalid}, 128'd0);
        @(negedge clk);
        chk("d1_rd_valid", {127'd0, d1_ovalid}, 128'd1);
        chk("d1_rd_data", d1_dout, LG);
        @(negedge clk);
        chk("d1_rd_ready", {126'd0, d1_ready, d1_ovalid}, 128'd2);

        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
